// File: rtl/alu_mc.sv
// Multi-cycle unsigned ALU with valid/ready input, iterative shift-add multiply,
// accumulator operand mode and a sticky error state cleared only by reset.
// state | meaning
// IDLE  | accepting commands; non-MULT ops complete at the accept edge
// MUL   | shift-add iterations, then completion on the edge after the last one
// ERR   | sticky error, inputs ignored until reset
module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_opcode,
  input  logic             i_use_acc,
  output logic [WIDTH-1:0] o_result,
  output logic             o_out_valid,
  output logic             o_status,
  output logic             o_busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ERR} state_t;

  state_t             r_state,    w_state_nxt;
  logic [WIDTH-1:0]   r_acc,      w_acc_nxt;
  logic [WIDTH-1:0]   r_result,   w_result_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [2*WIDTH-1:0] r_mcand,    w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier,   w_mplier_nxt;
  logic [2*WIDTH-1:0] r_prod,     w_prod_nxt;
  logic [CW-1:0]      r_cnt,      w_cnt_nxt;

  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_shl_wide;
  logic               w_shift_big;
  logic [WIDTH-1:0]   w_val;
  logic               w_err;

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state == S_MUL);
  assign o_status    = (r_state == S_ERR);
  assign o_result    = r_result;
  assign o_out_valid = r_out_valid;

  // Single-cycle operations, evaluated against the effective A operand
  always_comb begin
    w_op_a      = i_use_acc ? r_acc : i_a;
    w_sum       = {1'b0, w_op_a} + {1'b0, i_b};
    w_shl_wide  = {{WIDTH{1'b0}}, w_op_a} << i_b;
    w_shift_big = (i_b >= LP_W);
    w_val       = '0;
    w_err       = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_val = w_sum[WIDTH-1:0];
        w_err = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_val = w_op_a - i_b;
        w_err = (w_op_a < i_b);
      end
      OP_SHL: begin
        if (w_shift_big) begin
          w_err = (w_op_a != '0);
        end else begin
          w_val = w_shl_wide[WIDTH-1:0];
          w_err = (w_shl_wide[2*WIDTH-1:WIDTH] != '0);
        end
      end
      OP_SHR:  w_val = w_op_a >> i_b;
      OP_AND:  w_val = w_op_a & i_b;
      OP_OR:   w_val = w_op_a | i_b;
      OP_XOR:  w_val = w_op_a ^ i_b;
      OP_NOT:  w_val = ~w_op_a;
      OP_MULT: w_val = '0;
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_result_nxt    = r_result;
    w_out_valid_nxt = 1'b0;
    w_mcand_nxt     = r_mcand;
    w_mplier_nxt    = r_mplier;
    w_prod_nxt      = r_prod;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          if (i_opcode == OP_MULT) begin
            w_state_nxt  = S_MUL;
            w_mcand_nxt  = {{WIDTH{1'b0}}, w_op_a};
            w_mplier_nxt = i_b;
            w_prod_nxt   = '0;
            w_cnt_nxt    = CW'(WIDTH);
          end else begin
            w_out_valid_nxt = 1'b1;
            if (w_err) begin
              w_result_nxt = '0;
              w_state_nxt  = S_ERR;
            end else begin
              w_result_nxt = w_val;
              w_acc_nxt    = w_val;
            end
          end
        end
      end
      S_MUL: begin
        if (r_cnt != '0) begin
          w_prod_nxt   = r_prod + (r_mplier[0] ? r_mcand : '0);
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = r_mplier >> 1;
          w_cnt_nxt    = r_cnt - CW'(1);
        end else begin
          w_out_valid_nxt = 1'b1;
          if (r_prod[2*WIDTH-1:WIDTH] != '0) begin
            w_result_nxt = '0;
            w_state_nxt  = S_ERR;
          end else begin
            w_result_nxt = r_prod[WIDTH-1:0];
            w_acc_nxt    = r_prod[WIDTH-1:0];
            w_state_nxt  = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_result    <= w_result_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_prod      <= w_prod_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed plus randomized bench for alu_mc at WIDTH=16, checked against an
// arithmetic reference model of the command semantics.
module tb_alu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = '0;
  logic         use_acc = 1'b0;
  logic         o_in_ready, o_out_valid, o_status, o_busy;
  logic [W-1:0] o_result;

  int     n_vec = 0;
  int     n_err = 0;
  longint m_acc = 0;
  longint m_res = 0;
  bit     m_err = 0;

  alu_mc #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_a(a), .i_b(b), .i_opcode(opcode), .i_use_acc(use_acc),
    .o_result(o_result), .o_out_valid(o_out_valid), .o_status(o_status), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference semantics: unsigned math on wide integers, error when the true
  // result does not fit in W bits (or borrow / illegal opcode).
  function automatic void model(input int op, input longint x, input longint y,
                                output longint r, output bit e);
    longint m;
    m = longint'(1) << W;
    r = 0;
    e = 0;
    case (op)
      0: begin r = x + y; e = (r >= m); end
      1: begin e = (x < y); r = x - y; end
      2: begin r = x * y; e = (r >= m); end
      3: if (y >= W) e = (x != 0); else begin r = x << y; e = (r >= m); end
      4: r = (y >= W) ? 0 : (x >> y);
      5: r = x & y;
      6: r = x | y;
      7: r = x ^ y;
      8: r = (m - 1) - x;
      default: e = 1;
    endcase
    if (e) r = 0;
  endfunction

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_res = 0; m_err = 0;
    chk({tag, "/rst_result"}, 32'(o_result), 0);
    chk({tag, "/rst_status"}, 32'(o_status), 0);
    chk({tag, "/rst_ready"}, 32'(o_in_ready), 1);
    chk({tag, "/rst_busy"}, 32'(o_busy), 0);
    chk({tag, "/rst_ovalid"}, 32'(o_out_valid), 0);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, "/idle_ovalid"}, 32'(o_out_valid), 0);
    chk({tag, "/idle_status"}, 32'(o_status), 32'(m_err));
    chk({tag, "/idle_result"}, 32'(o_result), 32'(m_res));
  endtask

  // Issue one command at the current negedge; returns at the negedge where the
  // completion is visible, so consecutive calls run back-to-back.
  task automatic run_cmd(input int op, input longint x, input longint y, input bit ua,
                         input string tag);
    longint ea, r;
    bit e;
    int n;
    opcode = op[3:0]; a = x[W-1:0]; b = y[W-1:0]; use_acc = ua; in_valid = 1'b1;
    if (m_err) begin
      chk({tag, "/err_ready"}, 32'(o_in_ready), 0);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "/err_ovalid"}, 32'(o_out_valid), 0);
      chk({tag, "/err_status"}, 32'(o_status), 1);
      chk({tag, "/err_result"}, 32'(o_result), 0);
      return;
    end
    ea = ua ? m_acc : x;
    model(op, ea, y, r, e);
    chk({tag, "/ready"}, 32'(o_in_ready), 1);
    @(posedge clk); @(negedge clk);
    // inputs change after accept while in_valid stays high; must not matter
    a = W'($urandom); b = W'($urandom); opcode = 4'd0; use_acc = 1'b0;
    n = 0;
    while (!o_out_valid && n < 40) begin
      chk({tag, "/busy"}, 32'(o_busy), 1);
      chk({tag, "/notready"}, 32'(o_in_ready), 0);
      @(posedge clk); @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "/ovalid"}, 32'(o_out_valid), 1);
    chk({tag, "/latency"}, 32'(n), (op == 2) ? W + 1 : 0);
    chk({tag, "/result"}, 32'(o_result), 32'(r));
    chk({tag, "/status"}, 32'(o_status), 32'(e));
    m_res = r;
    if (e) m_err = 1; else m_acc = r;
  endtask

  initial begin
    int op;
    longint x, y;
    bit ua;

    do_reset("reset");
    run_cmd(0, 33, 45, 0, "add33_45");
    idle("add_pulse");

    run_cmd(1, 64, 30, 0, "sub64_30");
    run_cmd(5, 3855, 13107, 0, "and");
    run_cmd(6, 3855, 13107, 0, "or");
    run_cmd(7, 3855, 13107, 0, "xor");
    run_cmd(8, 3855, 0, 0, "not");
    run_cmd(3, 10, 1, 0, "shl10_1");
    run_cmd(4, 40000, 3, 0, "shr");
    run_cmd(4, 1, 16, 0, "shr_big");
    run_cmd(3, 0, 20, 0, "shl0_big");
    idle("b2b_end");

    run_cmd(2, 12, 12, 0, "mult12_12");
    run_cmd(0, 1, 2, 0, "after_mult");
    idle("mult_end");

    run_cmd(2, 9999, 9999, 0, "mult_ovf");
    idle("sticky_pulse");
    run_cmd(0, 1, 2, 0, "ignored1");
    run_cmd(0, 3, 4, 0, "ignored2");
    do_reset("sticky_clear");

    run_cmd(1, 30, 64, 0, "sub_borrow");
    do_reset("e1");
    run_cmd(0, 65535, 1, 0, "add_carry");
    do_reset("e2");
    run_cmd(3, 32768, 1, 0, "shl_out");
    do_reset("e3");
    run_cmd(3, 1, 16, 0, "shl_big");
    do_reset("e4");
    run_cmd(12, 5, 5, 0, "illegal12");
    do_reset("e5");

    run_cmd(0, 5, 0, 0, "acc_seed");
    run_cmd(0, 999, 7, 1, "acc_add");
    run_cmd(2, 999, 3, 1, "acc_mult");
    idle("acc_end");

    opcode = 4'd2; a = 16'd100; b = 16'd100; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort/busy", 32'(o_busy), 1);
      chk("abort/ovalid", 32'(o_out_valid), 0);
      @(posedge clk); @(negedge clk);
    end
    do_reset("abort");
    for (int i = 0; i < 20; i++) idle("abort_quiet");
    run_cmd(0, 12345, 1, 1, "abort_acc");

    for (int i = 0; i < 300; i++) begin
      if (m_err && $urandom_range(0, 2) == 0) do_reset("rnd_rst");
      op = $urandom_range(0, 9);
      if (op == 9) op = $urandom_range(9, 15);
      x = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 255)) : longint'($urandom_range(0, 65535));
      if (op == 3 || op == 4) y = $urandom_range(0, 18);
      else if (op == 2 || $urandom_range(0, 1) == 0) y = $urandom_range(0, 255);
      else y = $urandom_range(0, 65535);
      ua = ($urandom_range(0, 3) == 0);
      run_cmd(op, x, y, ua, "rnd");
      if ($urandom_range(0, 4) == 0) idle("rnd_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
